keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 107 ++++++++++
 tb/tb_keypad_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Five-button keypad encoder: synchronizes raw buttons, debounces press and release,
// and pulses key_valid (single key, with its code) or key_err (chord) once per press.
module keypad_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d1,
   input  logic       d2,
   input  logic       d3,
   input  logic       d4,
   input  logic       d5,
   output logic       key_valid,
   output logic [2:0] key_code,
   output logic       key_err,
   output logic       busy
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      EMIT,
      HELD,
      RELEASE_DB
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  sync_p0, sync_p1;
   logic [4:0]  s;
   logic [4:0]  p, p_nxt;
   logic [15:0] cnt, cnt_nxt;

   function automatic logic is_onehot(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

   function automatic logic [2:0] encode(input logic [4:0] v);
      logic [2:0] code;
      code = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (v[i]) code = 3'(i + 1);
      end
      return code;
   endfunction

   assign s = sync_p1;

   // Stage p0/p1: two-flop synchronizer, then state, counter, pattern and code registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0  <= 5'd0;
         sync_p1  <= 5'd0;
         state    <= IDLE;
         cnt      <= 16'd0;
         p        <= 5'd0;
         key_code <= 3'd0;
      end else begin
         sync_p0 <= {d5, d4, d3, d2, d1};
         sync_p1 <= sync_p0;
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         p       <= p_nxt;
         // Code lands together with the EMIT cycle so key_valid and key_code agree
         if (state_nxt == EMIT && is_onehot(p)) key_code <= encode(p);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      p_nxt     = p;
      case (state)
         IDLE: begin
            if (s != 5'd0) begin
               p_nxt     = s;
               cnt_nxt   = 16'd0;
               state_nxt = PRESS_DB;
            end
         end
         PRESS_DB: begin
            if (s != p)               state_nxt = IDLE;
            else if (cnt == CNT_LAST) state_nxt = EMIT;
            else                      cnt_nxt   = cnt + 16'd1;
         end
         EMIT: state_nxt = HELD;
         HELD: begin
            if (s == 5'd0) begin
               cnt_nxt   = 16'd0;
               state_nxt = RELEASE_DB;
            end
         end
         RELEASE_DB: begin
            if (s != 5'd0)            state_nxt = HELD;
            else if (cnt == CNT_LAST) state_nxt = IDLE;
            else                      cnt_nxt   = cnt + 16'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign key_valid = (state == EMIT) && is_onehot(p);
   assign key_err   = (state == EMIT) && !is_onehot(p);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a DEBOUNCE_CYCLES=4 instance for the functional
// cases and a default (500) instance for the long press sequence.
module tb_keypad_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       d1, d2, d3, d4, d5;
   logic       e1, e2, e3, e4, e5;
   logic       key_valid, key_err, busy;
   logic [2:0] key_code;
   logic       kv500, ke500, busy500;
   logic [2:0] kc500;

   int n_assert = 0;
   int n_fail   = 0;
   int nvalid   = 0;
   int nerr     = 0;
   int viol     = 0;
   int n500     = 0;
   logic [2:0] codes500 [0:3];
   logic       prev_pulse = 1'b0;
   int mark_v, mark_e;

   always #5 clk = ~clk;

   keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
      .key_valid(key_valid), .key_code(key_code), .key_err(key_err), .busy(busy)
   );

   keypad_encoder dut500 (
      .clk(clk), .reset(reset),
      .d1(e1), .d2(e2), .d3(e3), .d4(e4), .d5(e5),
      .key_valid(kv500), .key_code(kc500), .key_err(ke500), .busy(busy500)
   );

   // Pulse bookkeeping, sampled mid-cycle
   always @(negedge clk) begin
      if (key_valid) nvalid++;
      if (key_err) nerr++;
      if (key_valid && key_err) viol++;
      if ((key_valid || key_err) && prev_pulse) viol++;
      prev_pulse = key_valid || key_err;
      if (kv500) begin
         if (n500 < 4) codes500[n500] = kc500;
         n500++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      {d1, d2, d3, d4, d5} = 5'b0;
      {e1, e2, e3, e4, e5} = 5'b0;
      step(3);
      check("rst_valid", key_valid, 1'b0);
      check("rst_err", key_err, 1'b0);
      check("rst_code", key_code, 3'd0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      step(2);

      // Single key d2 held 20 cycles
      mark_v = nvalid; mark_e = nerr;
      d2 = 1'b1;
      step(6);
      check("d2_busy_db", busy, 1'b1);
      check("d2_early", key_valid, 1'b0);
      step(1);
      check("d2_valid", key_valid, 1'b1);
      check("d2_code", key_code, 3'd2);
      check("d2_err", key_err, 1'b0);
      step(1);
      check("d2_pulse_end", key_valid, 1'b0);
      step(12);
      d2 = 1'b0;
      step(6);
      check("d2_busy_rel", busy, 1'b1);
      step(1);
      check("d2_busy_fall", busy, 1'b0);
      check("d2_npulse", nvalid - mark_v, 1);
      check("d2_nerr", nerr - mark_e, 0);

      // Short glitch on d3
      mark_v = nvalid; mark_e = nerr;
      d3 = 1'b1;
      step(2);
      d3 = 1'b0;
      step(10);
      check("d3_npulse", nvalid - mark_v, 0);
      check("d3_nerr", nerr - mark_e, 0);
      check("d3_code", key_code, 3'd2);
      check("d3_idle", busy, 1'b0);

      // Chord d1+d4
      mark_v = nvalid; mark_e = nerr;
      d1 = 1'b1; d4 = 1'b1;
      step(7);
      check("chord_err", key_err, 1'b1);
      check("chord_valid", key_valid, 1'b0);
      check("chord_code", key_code, 3'd2);
      step(13);
      d1 = 1'b0; d4 = 1'b0;
      step(10);
      check("chord_nerr", nerr - mark_e, 1);
      check("chord_nvalid", nvalid - mark_v, 0);
      check("chord_idle", busy, 1'b0);

      // d5 with a 2-cycle drop mid-hold
      mark_v = nvalid; mark_e = nerr;
      d5 = 1'b1;
      step(10);
      d5 = 1'b0;
      step(2);
      d5 = 1'b1;
      step(10);
      check("d5_held", busy, 1'b1);
      d5 = 1'b0;
      step(10);
      check("d5_npulse", nvalid - mark_v, 1);
      check("d5_code", key_code, 3'd5);
      check("d5_nerr", nerr - mark_e, 0);
      check("d5_idle", busy, 1'b0);

      // Reset during PRESS_DB with d4 held
      mark_v = nvalid; mark_e = nerr;
      d4 = 1'b1;
      step(4);
      check("rdb_busy", busy, 1'b1);
      reset = 1'b1;
      step(1);
      check("rdb_busy0", busy, 1'b0);
      check("rdb_valid0", key_valid, 1'b0);
      check("rdb_err0", key_err, 1'b0);
      check("rdb_code0", key_code, 3'd0);
      step(3);
      check("rdb_nopulse", nvalid - mark_v, 0);
      reset = 1'b0;
      step(6);
      check("rdb_early", key_valid, 1'b0);
      step(1);
      check("rdb_valid", key_valid, 1'b1);
      check("rdb_code", key_code, 3'd4);
      d4 = 1'b0;
      step(10);
      check("rdb_npulse", nvalid - mark_v, 1);
      check("rdb_idle", busy, 1'b0);

      // Long-debounce instance: d2, d3, d1 each held 10 us then released 10 us
      e2 = 1'b1;
      step(502);
      check("l2_early", kv500, 1'b0);
      step(1);
      check("l2_valid", kv500, 1'b1);
      check("l2_code", kc500, 3'd2);
      step(497);
      e2 = 1'b0;
      step(1000);
      e3 = 1'b1;
      step(503);
      check("l3_valid", kv500, 1'b1);
      check("l3_code", kc500, 3'd3);
      step(497);
      e3 = 1'b0;
      step(1000);
      e1 = 1'b1;
      step(503);
      check("l1_valid", kv500, 1'b1);
      check("l1_code", kc500, 3'd1);
      step(497);
      e1 = 1'b0;
      step(1000);
      check("l_count", n500, 3);
      check("l_order0", codes500[0], 3'd2);
      check("l_order1", codes500[1], 3'd3);
      check("l_order2", codes500[2], 3'd1);
      check("l_err", ke500, 1'b0);
      check("l_idle", busy500, 1'b0);

      check("pulse_rules", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
